// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Stall / flush controller for the stallable pipeline registers
//               (PC, IF/ID, ID/EX, EX/MEM). Detects load-use hazards in ID,
//               holds the front end while a multi-cycle multiply occupies EX,
//               squashes younger instructions on a taken branch resolved in
//               MEM, and keeps a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int XZR     = 31,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] Rn_ID,
    input  logic [REG_W-1:0] Rm_ID,
    input  logic             UsesRn_ID,
    input  logic             UsesRm_ID,
    input  logic [REG_W-1:0] Rd_EX,
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic             MulStart_EX,
    input  logic             BranchTaken_MEM,
    output logic             Stall_PC,
    output logic             Stall_IFID,
    output logic             Stall_IDEX,
    output logic             Flush_IFID,
    output logic             Flush_IDEX,
    output logic             Flush_EXMEM,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCycles
);

    // Zero register index; writes to it never create a dependency.
    localparam logic [REG_W-1:0] C_XZR = REG_W'(XZR);

    // Wait-count loaded on multiply entry when MUL_WAIT is used (MUL_LAT > 2).
    localparam logic [3:0] C_WAIT_INIT = (MUL_LAT > 2) ? 4'(MUL_LAT - 2) : 4'd0;

    // With MUL_LAT == 2 the single stall cycle is the entry cycle itself, so
    // the FSM goes straight to MUL_LAST.
    localparam bit C_SKIP_WAIT = (MUL_LAT == 2);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_MUL_LAST = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    state_t           w_next_state;
    logic [3:0]       w_next_cnt;
    logic             w_lu;
    logic             w_mul_en;
    logic             w_rn_hit;
    logic             w_rm_hit;

    logic             w_stall_pc;
    logic             w_stall_ifid;
    logic             w_stall_idex;
    logic             w_flush_ifid;
    logic             w_flush_idex;
    logic             w_flush_exmem;

    // A single-cycle multiply needs no stall at all, so MulStart_EX is
    // masked off entirely in that build.
    generate
        if (MUL_LAT > 1) begin : g_mul_stall
            assign w_mul_en = MulStart_EX;
        end else begin : g_no_mul_stall
            assign w_mul_en = 1'b0;
        end
    endgenerate

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    assign w_rn_hit = UsesRn_ID && (Rn_ID == Rd_EX);
    assign w_rm_hit = UsesRm_ID && (Rm_ID == Rd_EX);
    assign w_lu     = MemRead_EX && RegWrite_EX && (Rd_EX != C_XZR)
                   && (w_rn_hit || w_rm_hit);

    // Mealy stall/flush decode and next-state logic; branch flush wins over
    // everything, and all controls are held low while reset is asserted.
    always_comb begin
        w_stall_pc    = 1'b0;
        w_stall_ifid  = 1'b0;
        w_stall_idex  = 1'b0;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_flush_exmem = 1'b0;
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;

        if (!Reset) begin
            w_next_state = ST_RUN;
            w_next_cnt   = 4'd0;
        end else if (BranchTaken_MEM) begin
            w_flush_ifid  = 1'b1;
            w_flush_idex  = 1'b1;
            w_flush_exmem = 1'b1;
            w_next_state  = ST_RUN;
            w_next_cnt    = 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mul_en) begin
                        // Freeze the front end and bubble EX/MEM while the
                        // multiply keeps EX busy.
                        w_stall_pc    = 1'b1;
                        w_stall_ifid  = 1'b1;
                        w_stall_idex  = 1'b1;
                        w_flush_exmem = 1'b1;
                        if (C_SKIP_WAIT) begin
                            w_next_state = ST_MUL_LAST;
                        end else begin
                            w_next_state = ST_MUL_WAIT;
                            w_next_cnt   = C_WAIT_INIT;
                        end
                    end else if (w_lu) begin
                        // One bubble is enough: next cycle the load is in MEM
                        // and forwarding covers the consumer.
                        w_stall_pc   = 1'b1;
                        w_stall_ifid = 1'b1;
                        w_flush_idex = 1'b1;
                    end
                end

                ST_MUL_WAIT: begin
                    w_stall_pc    = 1'b1;
                    w_stall_ifid  = 1'b1;
                    w_stall_idex  = 1'b1;
                    w_flush_exmem = 1'b1;
                    if (r_cnt == 4'd1) begin
                        w_next_state = ST_MUL_LAST;
                        w_next_cnt   = 4'd0;
                    end else begin
                        w_next_cnt = r_cnt - 4'd1;
                    end
                end

                ST_MUL_LAST: begin
                    // MulStart_EX is still high for the same multiply here,
                    // so only the load-use check applies.
                    if (w_lu) begin
                        w_stall_pc   = 1'b1;
                        w_stall_ifid = 1'b1;
                        w_flush_idex = 1'b1;
                    end
                    w_next_state = ST_RUN;
                end

                default: begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

    // State and wait-count registers.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall_pc && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign Stall_PC    = w_stall_pc;
    assign Stall_IFID  = w_stall_ifid;
    assign Stall_IDEX  = w_stall_idex;
    assign Flush_IFID  = w_flush_ifid;
    assign Flush_IDEX  = w_flush_idex;
    assign Flush_EXMEM = w_flush_exmem;
    assign Busy        = Reset && (r_state == ST_MUL_WAIT);
    assign StallCycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed self-checking bench for hazard_stall_ctrl. A second
//               instance with a 4-bit counter shares the stimulus to exercise
//               StallCycles saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       Reset;
    logic [4:0] Rn_ID, Rm_ID, Rd_EX;
    logic       UsesRn_ID, UsesRm_ID, MemRead_EX, RegWrite_EX;
    logic       MulStart_EX, BranchTaken_MEM;

    logic        sp, si, se, fi, fe, fm, busy;
    logic [31:0] cnt32;
    logic        sp_s, si_s, se_s, fi_s, fe_s, fm_s, busy_s;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(5), .MUL_LAT(4), .XZR(31), .CNT_W(32)) dut (
        .clk(clk), .Reset(Reset),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .UsesRn_ID(UsesRn_ID), .UsesRm_ID(UsesRm_ID),
        .Rd_EX(Rd_EX), .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
        .MulStart_EX(MulStart_EX), .BranchTaken_MEM(BranchTaken_MEM),
        .Stall_PC(sp), .Stall_IFID(si), .Stall_IDEX(se),
        .Flush_IFID(fi), .Flush_IDEX(fe), .Flush_EXMEM(fm),
        .Busy(busy), .StallCycles(cnt32)
    );

    hazard_stall_ctrl #(.REG_W(5), .MUL_LAT(4), .XZR(31), .CNT_W(4)) dut_sat (
        .clk(clk), .Reset(Reset),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .UsesRn_ID(UsesRn_ID), .UsesRm_ID(UsesRm_ID),
        .Rd_EX(Rd_EX), .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
        .MulStart_EX(MulStart_EX), .BranchTaken_MEM(BranchTaken_MEM),
        .Stall_PC(sp_s), .Stall_IFID(si_s), .Stall_IDEX(se_s),
        .Flush_IFID(fi_s), .Flush_IDEX(fe_s), .Flush_EXMEM(fm_s),
        .Busy(busy_s), .StallCycles(cnt4)
    );

    // Output vectors: {Stall_PC, Stall_IFID, Stall_IDEX, Flush_IFID, Flush_IDEX, Flush_EXMEM, Busy}
    wire [6:0] obs   = {sp, si, se, fi, fe, fm, busy};
    wire [6:0] obs_s = {sp_s, si_s, se_s, fi_s, fe_s, fm_s, busy_s};

    localparam logic [6:0] P_IDLE = 7'b000_000_0;
    localparam logic [6:0] P_LU   = 7'b110_010_0;
    localparam logic [6:0] P_MUL  = 7'b111_001_0;
    localparam logic [6:0] P_MULW = 7'b111_001_1;
    localparam logic [6:0] P_BR   = 7'b000_111_0;
    localparam logic [6:0] P_BRW  = 7'b000_111_1;

    typedef struct packed {
        logic [6:0]  o;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt  = 32'd0;
    logic [3:0]  exp_cnt4 = 4'd0;

    task automatic drv(input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm, input logic [4:0] rd,
                       input logic mr, input logic rw, input logic mul, input logic br);
        Rn_ID = rn; Rm_ID = rm; UsesRn_ID = urn; UsesRm_ID = urm;
        Rd_EX = rd; MemRead_EX = mr; RegWrite_EX = rw;
        MulStart_EX = mul; BranchTaken_MEM = br;
    endtask

    // Called at a falling edge with inputs already driven: queue expectation,
    // sample mid-cycle, then advance one clock and update the counter model.
    task automatic step(input string tag, input logic [6:0] exp_o);
        exp_t e;
        exp_t got;
        e.o = exp_o; e.cnt = exp_cnt; e.cnt4 = exp_cnt4;
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        checks++;
        assert (obs === got.o) else begin
            errors++;
            $error("FAIL %s outputs: observed %b expected %b", tag, obs, got.o);
        end
        checks++;
        assert (obs_s === got.o) else begin
            errors++;
            $error("FAIL %s outputs_cnt4: observed %b expected %b", tag, obs_s, got.o);
        end
        checks++;
        assert (cnt32 === got.cnt) else begin
            errors++;
            $error("FAIL %s StallCycles: observed %0d expected %0d", tag, cnt32, got.cnt);
        end
        checks++;
        assert (cnt4 === got.cnt4) else begin
            errors++;
            $error("FAIL %s StallCycles4: observed %0d expected %0d", tag, cnt4, got.cnt4);
        end
        @(posedge clk);
        if (!Reset) begin
            exp_cnt  = 32'd0;
            exp_cnt4 = 4'd0;
        end else if (exp_o[6]) begin
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 4'd1;
        end
        @(negedge clk);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset: everything forced low, even with all hazards asserted.
        step("reset_idle", P_IDLE);
        drv(3, 0, 1, 0, 3, 1, 1, 1, 1);
        step("reset_forced", P_IDLE);

        Reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle", P_IDLE);

        // Load-use on Rn, then on Rm; exactly one stall cycle each.
        drv(3, 0, 1, 0, 3, 1, 1, 0, 0);
        step("lu_rn", P_LU);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_rn_done", P_IDLE);
        drv(0, 7, 0, 1, 7, 1, 1, 0, 0);
        step("lu_rm", P_LU);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_rm_done", P_IDLE);

        // Non-hazards.
        drv(3, 0, 1, 0, 3, 1, 0, 0, 0);
        step("no_regwrite", P_IDLE);
        drv(3, 0, 1, 0, 3, 0, 1, 0, 0);
        step("no_memread", P_IDLE);
        drv(31, 0, 1, 0, 31, 1, 1, 0, 0);
        step("xzr", P_IDLE);
        drv(0, 5, 0, 0, 5, 1, 1, 0, 0);
        step("unused_rm", P_IDLE);

        // Multiply, MUL_LAT=4: three stall cycles, then one free cycle.
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mul_c0", P_MUL);
        step("mul_c1", P_MULW);
        step("mul_c2", P_MULW);
        step("mul_c3", P_IDLE);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mul_done", P_IDLE);

        // Multiply with a load-use present: ignored while waiting, honoured in MUL_LAST.
        drv(3, 0, 1, 0, 3, 1, 1, 1, 0);
        step("mullu_c0", P_MUL);
        step("mullu_c1", P_MULW);
        step("mullu_c2", P_MULW);
        step("mullu_c3", P_LU);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mullu_done", P_IDLE);

        // Branch overrides multiply and load-use; state remains RUN.
        drv(3, 0, 1, 0, 3, 1, 1, 1, 1);
        step("br_prio", P_BR);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("br_then_mul", P_MUL);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("br_abort_wait", P_BRW);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("after_abort", P_MUL);

        // Reset in the second MUL_WAIT cycle.
        step("rst_mul_c1", P_MULW);
        Reset = 1'b0;
        step("rst_mul_c2", P_IDLE);
        Reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_release", P_IDLE);

        // Fresh multiply after reset.
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mul2_c0", P_MUL);
        step("mul2_c1", P_MULW);
        step("mul2_c2", P_MULW);
        step("mul2_c3", P_IDLE);

        // Persistent load-use for 20 cycles saturates the 4-bit counter.
        drv(9, 0, 1, 0, 9, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step("sat_lu", P_LU);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("sat_final", P_IDLE);
        step("sat_hold", P_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
